// File: rtl/reg_obs_scanner.sv
// Walks the CPU register observation port index by index and streams {index, data}
// into a small FIFO. Runs one pass or repeated passes, and stalls rather than dropping entries.
module reg_obs_scanner #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int SEL_W  = 5,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              stop,
  output logic [SEL_W-1:0]  reg_obs_sel,
  input  logic [DATA_W-1:0] reg_obs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = SEL_W + DATA_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NREG - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              mode_q, mode_d;
  logic              stop_pend_q, stop_pend_d;
  logic [15:0]       pass_q, pass_d;
  logic              done_q, done_d;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full, empty, push, pop;

  // Full is judged on the registered count, so a pop never frees a slot for the same cycle.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = (state_q == SCAN) && !full;
  assign pop   = !empty && out_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          sel_d       = '0;
          pass_d      = '0;
          stop_pend_d = 1'b0;
          mode_d      = mode;
        end
      end
      SCAN: begin
        if (stop) stop_pend_d = 1'b1;
        if (push) begin
          if (sel_q == LAST_SEL) begin
            pass_d = pass_q + 16'd1;
            // A stop arriving on the final push still ends the scan at this pass.
            if (!mode_q || stop_pend_q || stop) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              sel_d = '0;
            end
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      pass_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_q, reg_obs_data};
  end

  assign {out_idx, out_data} = mem_q[rd_ptr_q];
  assign out_valid   = !empty;
  assign reg_obs_sel = sel_q;
  assign busy        = (state_q == SCAN);
  assign done        = done_q;
  assign pass_cnt    = pass_q;

endmodule
